// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard stall unit.
//   - mul_state_e  : multiply timer FSM states
//   - REASON_*     : stall_reason encodings driven on the stall_reason_o port
//   - REG_ADDR_W_DEFAULT, MUL_CNT_W : default register-address width, multiply counter width
package hazard_pkg;

    localparam int unsigned REG_ADDR_W_DEFAULT = 3;
    localparam int unsigned MUL_CNT_W          = 4;

    typedef enum logic {
        StRun,
        StMulBusy
    } mul_state_e;

    localparam logic [2:0] REASON_NONE    = 3'd0;
    localparam logic [2:0] REASON_MEM     = 3'd1;
    localparam logic [2:0] REASON_MUL     = 3'd2;
    localparam logic [2:0] REASON_BRANCH  = 3'd3;
    localparam logic [2:0] REASON_LOADUSE = 3'd4;

endpackage

// File: rtl/hazard_mul_timer.sv
// Multiply occupancy timer for the EX stage.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mul_start_i    EX instruction is a multiply
//   hold_i         freeze the timer (data-memory stall owns this cycle)
//   mul_stall_o    multiply needs the front of the pipeline held this cycle
//   mul_done_o     final occupancy cycle; multiplier may release its result
module hazard_mul_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mul_start_i,
    input  logic hold_i,
    output logic mul_stall_o,
    output logic mul_done_o
);

    localparam logic [MUL_CNT_W-1:0] MulLoad = MUL_CNT_W'(MUL_LAT - 1);

    mul_state_e           state_q;
    logic [MUL_CNT_W-1:0] mul_cnt_q;

    // mul_cnt_q counts the remaining EX cycles, the last of which (cnt==1) is the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            mul_cnt_q <= '0;
        end else if (!hold_i) begin
            unique case (state_q)
                StRun: begin
                    if (mul_start_i) begin
                        state_q   <= StMulBusy;
                        mul_cnt_q <= MulLoad;
                    end
                end
                StMulBusy: begin
                    if (mul_cnt_q > MUL_CNT_W'(1)) begin
                        mul_cnt_q <= mul_cnt_q - MUL_CNT_W'(1);
                    end else begin
                        state_q   <= StRun;
                        mul_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= StRun;
                    mul_cnt_q <= '0;
                end
            endcase
        end
    end

    assign mul_stall_o = (state_q == StRun) ? mul_start_i : (mul_cnt_q > MUL_CNT_W'(1));
    assign mul_done_o  = (state_q == StMulBusy) && (mul_cnt_q == MUL_CNT_W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard stall/flush controller for a 5-stage pipeline. Covers the hazards operand
// forwarding cannot: data-memory wait, multi-cycle multiply, taken branch and load-use.
// Priority: mem wait > multiply > taken branch > load-use.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   id_rs_i, id_rt_i, id_uses_*_i      ID-stage source registers and their use flags
//   ex_rd_i, ex_memread_i, ex_regwrite_i, ex_branch_taken_i, ex_mul_start_i  EX-stage info
//   mem_req_i, mem_ready_i             MEM-stage access request / completion
//   *_write_o                          pipeline register load enables
//   ifid_flush_o, *_bubble_o           NOP insertion controls
//   mul_done_o                         one-cycle multiplier release pulse
//   stall_reason_o                     REASON_* code of the winning hazard
//   perf_stall_cycles_o, perf_flushes_o  saturating counters
// Optional feature: macro HAZARD_PERF_EN builds the performance counters; without it both
// counter ports are tied to zero.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_memread_i,
    input  logic                  ex_regwrite_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  ex_mul_start_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  idex_write_o,
    output logic                  exmem_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  exmem_bubble_o,
    output logic                  memwb_bubble_o,
    output logic                  mul_done_o,
    output logic [2:0]            stall_reason_o,
    output logic [PERF_W-1:0]     perf_stall_cycles_o,
    output logic [PERF_W-1:0]     perf_flushes_o
);

    logic mem_stall;
    logic mul_stall;
    logic mul_done;
    logic load_use;

    assign mem_stall = mem_req_i && !mem_ready_i;
    assign load_use  = ex_memread_i && ex_regwrite_i &&
                       ((id_uses_rs_i && (id_rs_i == ex_rd_i)) ||
                        (id_uses_rt_i && (id_rt_i == ex_rd_i)));

    // A mem stall freezes EX, so the multiply timer must not advance either.
    hazard_mul_timer #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .mul_start_i (ex_mul_start_i),
        .hold_i      (mem_stall),
        .mul_stall_o (mul_stall),
        .mul_done_o  (mul_done)
    );

    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_write_o   = 1'b0;
        exmem_write_o  = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        memwb_bubble_o = 1'b0;
        mul_done_o     = 1'b0;
        stall_reason_o = REASON_NONE;
        if (rst_n) begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_write_o  = 1'b1;
            exmem_write_o = 1'b1;
            if (mem_stall) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_write_o  = 1'b0;
                memwb_bubble_o = 1'b1;
                stall_reason_o = REASON_MEM;
            end else if (mul_stall) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_bubble_o = 1'b1;
                stall_reason_o = REASON_MUL;
            end else if (mul_done) begin
                // Busy state with no stall and no done is impossible, so the branch and
                // load-use arms below are only reachable in RUN.
                mul_done_o = 1'b1;
            end else if (ex_branch_taken_i) begin
                // Wins over load-use: the dependent instruction is on the wrong path.
                ifid_flush_o   = 1'b1;
                idex_bubble_o  = 1'b1;
                stall_reason_o = REASON_BRANCH;
            end else if (load_use) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_bubble_o  = 1'b1;
                stall_reason_o = REASON_LOADUSE;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] PerfOne = PERF_W'(1);

    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!pc_write_o && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + PerfOne;
            end
            if ((stall_reason_o == REASON_BRANCH) && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + PerfOne;
            end
        end
    end

    assign perf_stall_cycles_o = perf_stall_q;
    assign perf_flushes_o      = perf_flush_q;
`else
    assign perf_stall_cycles_o = '0;
    assign perf_flushes_o      = '0;
`endif

    // A multiply in EX cannot also be a load or a taken branch.
    illegal_mul_combo: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_mul_start_i && (ex_branch_taken_i || ex_memread_i)));

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned PERF_W  = 16;
    localparam int          PERF_MAX = (1 << PERF_W) - 1;

    logic              clk;
    logic              rst_n;
    logic [2:0]        id_rs, id_rt, ex_rd;
    logic              id_uses_rs, id_uses_rt;
    logic              ex_memread, ex_regwrite, ex_branch_taken, ex_mul_start;
    logic              mem_req, mem_ready;
    logic              pc_write, ifid_write, idex_write, exmem_write;
    logic              ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, mul_done;
    logic [2:0]        stall_reason;
    logic [PERF_W-1:0] perf_stall_cycles, perf_flushes;

    hazard_stall_unit #(
        .REG_ADDR_W (3),
        .MUL_LAT    (MUL_LAT),
        .PERF_W     (PERF_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .id_rs_i             (id_rs),
        .id_rt_i             (id_rt),
        .id_uses_rs_i        (id_uses_rs),
        .id_uses_rt_i        (id_uses_rt),
        .ex_rd_i             (ex_rd),
        .ex_memread_i        (ex_memread),
        .ex_regwrite_i       (ex_regwrite),
        .ex_branch_taken_i   (ex_branch_taken),
        .ex_mul_start_i      (ex_mul_start),
        .mem_req_i           (mem_req),
        .mem_ready_i         (mem_ready),
        .pc_write_o          (pc_write),
        .ifid_write_o        (ifid_write),
        .idex_write_o        (idex_write),
        .exmem_write_o       (exmem_write),
        .ifid_flush_o        (ifid_flush),
        .idex_bubble_o       (idex_bubble),
        .exmem_bubble_o      (exmem_bubble),
        .memwb_bubble_o      (memwb_bubble),
        .mul_done_o          (mul_done),
        .stall_reason_o      (stall_reason),
        .perf_stall_cycles_o (perf_stall_cycles),
        .perf_flushes_o      (perf_flushes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [2:0] rs, rt, rd;
        logic       uses_rs, uses_rt, memread, regwrite, branch, mul_start, mem_req, mem_ready;
    } stim_t;

    typedef struct {
        int                cyc;
        logic [11:0]       outs;
        logic [PERF_W-1:0] ps;
        logic [PERF_W-1:0] pf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: a multiply occupies EX for MUL_LAT unfrozen cycles; the first
    // MUL_LAT-1 of them stall, the last one releases the result.
    bit m_busy = 1'b0;
    int m_age = 0;           // unfrozen EX cycles already spent by the current multiply
    int m_stalls = 0;
    int m_flushes = 0;

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   mem, lu, ms, md;
        bit   pcw, ifw, idw, exw, fl, idb, exb, mwb, dn;
        logic [2:0] r;
        @(posedge clk);
        #1;
        rst_n = s.rst; id_rs = s.rs; id_rt = s.rt; ex_rd = s.rd;
        id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt;
        ex_memread = s.memread; ex_regwrite = s.regwrite; ex_branch_taken = s.branch;
        ex_mul_start = s.mul_start; mem_req = s.mem_req; mem_ready = s.mem_ready;
        cyc++;
        e.cyc = cyc;
        if (!s.rst) begin
            m_busy = 1'b0; m_age = 0; m_stalls = 0; m_flushes = 0;
            e.outs = '0; e.ps = '0; e.pf = '0;
        end else begin
`ifdef HAZARD_PERF_EN
            e.ps = PERF_W'(m_stalls);
            e.pf = PERF_W'(m_flushes);
`else
            e.ps = '0;
            e.pf = '0;
`endif
            mem = s.mem_req && !s.mem_ready;
            lu  = s.memread && s.regwrite &&
                  ((s.uses_rs && s.rs == s.rd) || (s.uses_rt && s.rt == s.rd));
            ms  = m_busy ? (m_age < MUL_LAT - 1) : s.mul_start;
            md  = m_busy && (m_age == MUL_LAT - 1);
            {pcw, ifw, idw, exw} = 4'b1111;
            {fl, idb, exb, mwb, dn} = 5'b0;
            r = 3'd0;
            if (mem) begin
                {pcw, ifw, idw, exw} = 4'b0000; mwb = 1'b1; r = 3'd1;
            end else if (ms) begin
                {pcw, ifw, idw} = 3'b000; exb = 1'b1; r = 3'd2;
            end else if (md) begin
                dn = 1'b1;
            end else if (s.branch) begin
                fl = 1'b1; idb = 1'b1; r = 3'd3;
            end else if (lu) begin
                pcw = 1'b0; ifw = 1'b0; idb = 1'b1; r = 3'd4;
            end
            e.outs = {pcw, ifw, idw, exw, fl, idb, exb, mwb, dn, r};
            if (!mem) begin
                if (!m_busy && s.mul_start) begin
                    m_busy = 1'b1; m_age = 1;
                end else if (m_busy) begin
                    if (m_age == MUL_LAT - 1) begin m_busy = 1'b0; m_age = 0; end
                    else m_age++;
                end
            end
            if (!pcw && m_stalls < PERF_MAX) m_stalls++;
            if (r == 3'd3 && m_flushes < PERF_MAX) m_flushes++;
        end
        sb_q.push_back(e);
    endtask

    task automatic apply_n(input stim_t s, input int n);
        for (int i = 0; i < n; i++) apply(s);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    exp_t        mon_e;
    logic [11:0] mon_got;
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_e   = sb_q.pop_front();
                mon_got = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
                           idex_bubble, exmem_bubble, memwb_bubble, mul_done, stall_reason};
                checks++;
                if (mon_got !== mon_e.outs) begin
                    errors++;
                    $display("FAIL ctrl cycle %0d: got %b expected %b (pc,ifid,idex,exmem,flush,idexb,exmemb,memwbb,done,reason)",
                             mon_e.cyc, mon_got, mon_e.outs);
                end
                checks++;
                if (perf_stall_cycles !== mon_e.ps || perf_flushes !== mon_e.pf) begin
                    errors++;
                    $display("FAIL perf cycle %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             mon_e.cyc, perf_stall_cycles, perf_flushes, mon_e.ps, mon_e.pf);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        {id_rs, id_rt, ex_rd} = '0;
        {id_uses_rs, id_uses_rt, ex_memread, ex_regwrite} = '0;
        {ex_branch_taken, ex_mul_start, mem_req, mem_ready} = '0;

        s = idle_s(); s.rst = 1'b0;
        apply_n(s, 2);
        apply_n(idle_s(), 2);

        // Load-use on rs, then the same without the rs use.
        s = idle_s(); s.memread = 1; s.regwrite = 1; s.rd = 3; s.rs = 3; s.uses_rs = 1;
        apply(s);
        apply(idle_s());
        s.uses_rs = 0;
        apply(s);
        // Load-use through rt.
        s = idle_s(); s.memread = 1; s.regwrite = 1; s.rd = 5; s.rt = 5; s.uses_rt = 1;
        apply(s);

        // Multiply held in EX: three stall cycles then the done cycle.
        s = idle_s(); s.mul_start = 1;
        apply_n(s, MUL_LAT);
        apply(idle_s());

        // Memory wait for five cycles, released by mem_ready.
        s = idle_s(); s.mem_req = 1;
        apply_n(s, 5);
        s.mem_ready = 1;
        apply(s);
        apply(idle_s());

        // Memory stall arriving mid-multiply freezes the multiply countdown.
        s = idle_s(); s.mul_start = 1;
        apply_n(s, 2);
        s.mem_req = 1;
        apply_n(s, 2);
        s.mem_req = 0;
        apply_n(s, 2);
        apply(idle_s());

        // Taken branch coincident with a load-use hazard.
        s = idle_s(); s.branch = 1; s.memread = 1; s.regwrite = 1; s.rd = 2; s.rs = 2;
        s.uses_rs = 1;
        apply(s);
        apply(idle_s());

        // Reset asserted mid-multiply, then released.
        s = idle_s(); s.mul_start = 1;
        apply_n(s, 2);
        s.rst = 0;
        apply_n(s, 2);
        apply_n(idle_s(), 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = idle_s();
            s.rst       = ($urandom_range(0, 199) != 0);
            s.rs        = 3'($urandom_range(0, 7));
            s.rt        = 3'($urandom_range(0, 7));
            s.rd        = ($urandom_range(0, 2) == 0) ? s.rs : 3'($urandom_range(0, 7));
            s.uses_rs   = 1'($urandom_range(0, 1));
            s.uses_rt   = 1'($urandom_range(0, 1));
            s.memread   = ($urandom_range(0, 2) == 0);
            s.regwrite  = 1'($urandom_range(0, 1));
            s.branch    = ($urandom_range(0, 4) == 0);
            s.mul_start = m_busy ? 1'b1 : ($urandom_range(0, 7) == 0);
            if (s.mul_start) begin
                s.branch  = 1'b0;
                s.memread = 1'b0;
            end
            s.mem_req   = ($urandom_range(0, 3) == 0);
            s.mem_ready = 1'($urandom_range(0, 1));
            apply(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
